// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/status outputs of the PC sequencer.
interface pc_sequencer_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             i_stall;
   logic             i_ctrl_valid;
   logic             i_is_branch;
   logic             i_is_jal;
   logic             i_is_jalr;
   logic [2:0]       i_funct3;
   logic [XLEN-1:0]  i_rs1_val;
   logic [XLEN-1:0]  i_rs2_val;
   logic [XLEN-1:0]  i_immediate;
   logic             i_trap;
   logic [XLEN-1:0]  o_pc;
   logic [XLEN-1:0]  o_pc_plus4;
   logic             o_pc_valid;
   logic             o_fault;
   logic [CNT_W-1:0] o_taken_cnt;
   logic [CNT_W-1:0] o_retire_cnt;
   modport master (
      output i_stall, i_ctrl_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
             i_rs1_val, i_rs2_val, i_immediate, i_trap,
      input  o_pc, o_pc_plus4, o_pc_valid, o_fault, o_taken_cnt, o_retire_cnt
   );
   modport slave (
      input  i_stall, i_ctrl_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
             i_rs1_val, i_rs2_val, i_immediate, i_trap,
      output o_pc, o_pc_plus4, o_pc_valid, o_fault, o_taken_cnt, o_retire_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: BOOT/RUN/HALT program-counter sequencer with branch resolution,
// misaligned-target fault, trap redirect and taken/retire event counters.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int              CNT_W        = 16
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);
   state_t           r_state, w_state_nx;
   logic [XLEN-1:0]  r_pc, w_pc_nx;
   logic             r_fault, w_fault_nx;
   logic [CNT_W-1:0] r_taken, w_taken_nx, r_retire, w_retire_nx;
   logic [XLEN-1:0]  w_pc_plus4, w_jalr_sum, w_target;
   logic             w_eq, w_lt_s, w_lt_u, w_cond, w_jump;
   assign w_pc_plus4 = r_pc + FOUR;
   assign w_eq       = bus.i_rs1_val == bus.i_rs2_val;
   assign w_lt_s     = $signed(bus.i_rs1_val) < $signed(bus.i_rs2_val);
   assign w_lt_u     = bus.i_rs1_val < bus.i_rs2_val;
   assign w_cond     = bus.i_funct3 == 3'b000 ? w_eq :
                       bus.i_funct3 == 3'b001 ? !w_eq :
                       bus.i_funct3 == 3'b100 ? w_lt_s :
                       bus.i_funct3 == 3'b101 ? !w_lt_s :
                       bus.i_funct3 == 3'b110 ? w_lt_u :
                       bus.i_funct3 == 3'b111 ? !w_lt_u : 1'b0;
   assign w_jump     = bus.i_is_jalr || bus.i_is_jal || (bus.i_is_branch && w_cond);
   assign w_jalr_sum = bus.i_rs1_val + bus.i_immediate;
   // jalr outranks jal/branch, which share the pc-relative target
   assign w_target   = bus.i_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : r_pc + bus.i_immediate;
   always_comb begin
      w_state_nx  = r_state;
      w_pc_nx     = r_pc;
      w_fault_nx  = r_fault;
      w_taken_nx  = r_taken;
      w_retire_nx = r_retire;
      if (!bus.i_stall) begin
         if (r_state == BOOT) begin
            w_state_nx = RUN;
         end else if (bus.i_trap) begin
            w_state_nx = RUN;
            w_pc_nx    = TRAP_VECTOR;
            w_fault_nx = 1'b0;
         end else if (r_state == RUN && bus.i_ctrl_valid) begin
            if (w_jump && w_target[1]) begin
               w_state_nx = HALT;
               w_fault_nx = 1'b1;
            end else begin
               w_pc_nx     = w_jump ? w_target : w_pc_plus4;
               w_retire_nx = r_retire + 1'b1;
               w_taken_nx  = r_taken + CNT_W'(w_jump);
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= BOOT;
         r_pc     <= RESET_VECTOR;
         r_fault  <= 1'b0;
         r_taken  <= '0;
         r_retire <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_pc     <= w_pc_nx;
         r_fault  <= w_fault_nx;
         r_taken  <= w_taken_nx;
         r_retire <= w_retire_nx;
      end
   end
   assign bus.o_pc         = r_pc;
   assign bus.o_pc_plus4   = w_pc_plus4;
   assign bus.o_pc_valid   = r_state == RUN;
   assign bus.o_fault      = r_fault;
   assign bus.o_taken_cnt  = r_taken;
   assign bus.o_retire_cnt = r_retire;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Parameters
REQ-001 XLEN, default 32, datapath and PC width.
REQ-002 RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-003 TRAP_VECTOR, default 32'h0000_0100, PC value loaded on trap.
REQ-004 CNT_W, default 16, width of the taken-branch and retire counters.

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  freeze all state this cycle.
REQ-008 ctrl_valid  in  1  control inputs describe the instruction at pc.
REQ-009 is_branch  in  1  conditional branch.
REQ-010 is_jal  in  1  PC-relative jump.
REQ-011 is_jalr  in  1  register-indirect jump.
REQ-012 funct3  in  3  branch condition select.
REQ-013 rs1_val, rs2_val  in  XLEN  operands; signed or unsigned per funct3.
REQ-014 immediate  in  XLEN  sign-extended offset, LSB already appended by decode.
REQ-015 trap  in  1  redirect to TRAP_VECTOR.
REQ-016 pc  out  XLEN  current fetch address.
REQ-017 pc_plus4  out  XLEN  pc+4, combinational link value.
REQ-018 pc_valid  out  1  high only in RUN.
REQ-019 fault  out  1  misaligned control-transfer target latched.
REQ-020 taken_cnt, retire_cnt  out  CNT_W  free-running event counters.

Function
REQ-021 FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally on the next un-stalled edge, pc unchanged.
REQ-022 Branch condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken.
REQ-023 Target: branch/jal = pc+immediate; jalr = (rs1_val+immediate) with bit 0 cleared; all sums modulo 2^XLEN, wrap silently.
REQ-024 In RUN with ctrl_valid: jal or jalr, or a taken branch, loads target; otherwise pc <= pc+4.
REQ-025 In RUN with ctrl_valid low: pc holds and counters hold.
REQ-026 Control-input priority when more than one is set: jalr > jal > is_branch.
REQ-027 A target with bit 1 set is misaligned: pc holds, fault <= 1, state -> HALT, counters hold.
REQ-028 In HALT: pc_valid=0, pc holds, ctrl_valid ignored; only trap or reset exits.
REQ-029 trap in RUN or HALT: pc <= TRAP_VECTOR, fault <= 0, state -> RUN; trap beats every control input the same cycle; trap in BOOT is ignored.
REQ-030 stall high: pc, state, fault and counters all hold, trap included; stall has priority over everything except reset.
REQ-031 taken_cnt += 1 on each accepted jal, jalr or taken branch; retire_cnt += 1 on each accepted ctrl_valid cycle that updates pc; both wrap at 2^CNT_W.

Reset
REQ-032 reset asserted: immediately pc=RESET_VECTOR, state=BOOT, pc_valid=0, fault=0, taken_cnt=0, retire_cnt=0.
REQ-033 reset mid-HALT or mid-stall: same values; reset dominates all inputs.

Verification
REQ-034 Release reset, ctrl_valid=1 with no control set for 3 cycles -> pc 0, 0 (BOOT), 4, 8, 12; retire_cnt=3.
REQ-035 pc=0x10, is_branch, funct3=100, rs1=0xFFFF_FFFF, rs2=1, imm=-8 -> pc=0x08, taken_cnt+1; same operands with funct3=110 -> pc=0x14.
REQ-036 pc=0x20, is_jalr, rs1=0x1001, imm=2 -> pc=0x1002 is misaligned -> pc stays 0x20, fault=1, pc_valid=0; trap next cycle -> pc=0x100, fault=0.
REQ-037 stall=1 with is_jal, imm=0x40 and trap=1 -> pc, counters unchanged; stall released with jal only -> pc += 0x40.
REQ-038 CNT_W=2, five taken jumps -> taken_cnt sequence 1,2,3,0,1; pc=0xFFFF_FFFC plus 4 -> pc=0.
